// File: rtl/serial_to_parallel_converter.sv
// Serial-to-parallel converter: assembles W-bit words LSB first, with framing checks,
// an idle-gap timeout and a one-word ready/valid output register.
module serial_to_parallel_converter #(
   parameter int unsigned W       = 4,
   parameter int unsigned GAP_MAX = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         serial_i,
   input  logic         valid_i,
   input  logic         empty_i,
   output logic [W-1:0] parallel_o,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic         busy_o,
   output logic         frame_err_o,
   output logic         overrun_o,
   input  logic         clr_err_i
);

   localparam int unsigned CW = $clog2(W);
   localparam int unsigned GW = $clog2(GAP_MAX + 1);
   localparam logic [CW-1:0] CntLast = CW'(W - 1);
   localparam logic [GW-1:0] GapLast = GW'(GAP_MAX - 1);

   typedef enum logic {StIdle, StRecv} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [W-1:0]  sr_q, sr_d;
   logic [W-1:0]  par_q, par_d;
   logic          out_valid_q, out_valid_d;
   logic          ferr_q, ferr_d;
   logic          ovr_q, ovr_d;
   logic          word_done;
   logic [W-1:0]  word;
   logic          load;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         gap_q       <= '0;
         sr_q        <= '0;
         par_q       <= '0;
         out_valid_q <= 1'b0;
         ferr_q      <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         sr_q        <= sr_d;
         par_q       <= par_d;
         out_valid_q <= out_valid_d;
         ferr_q      <= ferr_d;
         ovr_q       <= ovr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      sr_d      = sr_q;
      ferr_d    = 1'b0;
      word_done = 1'b0;
      // Full word is the held bits plus the bit arriving this cycle in the MSB.
      word        = sr_q;
      word[W-1]   = serial_i;

      unique case (state_q)
         StIdle: begin
            if (empty_i) begin
               ferr_d = valid_i;
            end else if (valid_i) begin
               sr_d[0] = serial_i;
               cnt_d   = CW'(1);
               gap_d   = '0;
               state_d = StRecv;
            end
         end
         StRecv: begin
            if (empty_i) begin
               ferr_d  = 1'b1;
               cnt_d   = '0;
               gap_d   = '0;
               state_d = StIdle;
            end else if (valid_i) begin
               sr_d[cnt_q] = serial_i;
               gap_d       = '0;
               if (cnt_q == CntLast) begin
                  word_done = 1'b1;
                  cnt_d     = '0;
                  state_d   = StIdle;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (gap_q == GapLast) begin
               ferr_d  = 1'b1;
               cnt_d   = '0;
               gap_d   = '0;
               state_d = StIdle;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      load  = word_done && (!out_valid_q || out_ready_i);
      par_d = load ? word : par_q;
      if (load) begin
         out_valid_d = 1'b1;
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
      // A fresh drop takes priority over a clear in the same cycle.
      if (word_done && out_valid_q && !out_ready_i) begin
         ovr_d = 1'b1;
      end else if (clr_err_i) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   assign parallel_o  = par_q;
   assign out_valid_o = out_valid_q;
   assign busy_o      = (state_q == StRecv);
   assign frame_err_o = ferr_q;
   assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_serial_to_parallel_converter.sv
// Bench for serial_to_parallel_converter: directed scenarios plus random traffic,
// all checked against a queue-based behavioural model.
module tb_serial_to_parallel_converter;

   localparam int unsigned W       = 4;
   localparam int unsigned GAP_MAX = 8;

   logic         clk = 1'b0;
   logic         reset, serial_i, valid_i, empty_i, out_ready_i, clr_err_i;
   logic [W-1:0] parallel_o;
   logic         out_valid_o, busy_o, frame_err_o, overrun_o;

   int n_cmp = 0;
   int n_bad = 0;

   bit           m_bits[$];
   int           m_gap;
   logic [W-1:0] m_word;
   logic         m_valid, m_ferr, m_ovr;

   serial_to_parallel_converter #(.W(W), .GAP_MAX(GAP_MAX)) dut (
      .clk         (clk),
      .reset       (reset),
      .serial_i    (serial_i),
      .valid_i     (valid_i),
      .empty_i     (empty_i),
      .parallel_o  (parallel_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .busy_o      (busy_o),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o),
      .clr_err_i   (clr_err_i)
   );

   always #5 clk = ~clk;

   task automatic check_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_b(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   // Predicts the registered outputs after the coming clock edge.
   task automatic model_step();
      logic         done;
      logic         ferr;
      logic [W-1:0] w;
      done = 1'b0;
      ferr = 1'b0;
      w    = '0;
      if (reset) begin
         m_bits.delete();
         m_gap   = 0;
         m_word  = '0;
         m_valid = 1'b0;
         m_ferr  = 1'b0;
         m_ovr   = 1'b0;
         return;
      end
      if (empty_i) begin
         ferr = valid_i || (m_bits.size() != 0);
         m_bits.delete();
         m_gap = 0;
      end else if (valid_i) begin
         m_bits.push_back(serial_i);
         m_gap = 0;
         if (m_bits.size() == W) begin
            foreach (m_bits[i]) w[i] = m_bits[i];
            done = 1'b1;
            m_bits.delete();
         end
      end else if (m_bits.size() != 0) begin
         m_gap++;
         if (m_gap == GAP_MAX) begin
            ferr = 1'b1;
            m_bits.delete();
            m_gap = 0;
         end
      end
      if (done && m_valid && !out_ready_i) m_ovr = 1'b1;
      else if (clr_err_i)                  m_ovr = 1'b0;
      if (done && (!m_valid || out_ready_i)) begin
         m_valid = 1'b1;
         m_word  = w;
      end else if (m_valid && out_ready_i) begin
         m_valid = 1'b0;
      end
      m_ferr = ferr;
   endtask

   task automatic cyc(input logic s, input logic v, input logic e, input logic r,
                      input logic c, input logic rst);
      serial_i    = s;
      valid_i     = v;
      empty_i     = e;
      out_ready_i = r;
      clr_err_i   = c;
      reset       = rst;
      model_step();
      @(posedge clk);
      #1;
      check_w("parallel_o", parallel_o, m_word);
      check_b("out_valid_o", out_valid_o, m_valid);
      check_b("busy_o", busy_o, m_bits.size() != 0);
      check_b("frame_err_o", frame_err_o, m_ferr);
      check_b("overrun_o", overrun_o, m_ovr);
   endtask

   task automatic send_word(input logic [W-1:0] val, input logic r);
      for (int i = 0; i < W; i++) cyc(val[i], 1'b1, 1'b0, r, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, r, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_w("reset_parallel", parallel_o, 4'h0);
      check_b("reset_valid", out_valid_o, 1'b0);

      // Basic word 1,0,1,1 then boundary marker
      send_word(4'hD, 1'b1);
      check_w("basic_word", parallel_o, 4'hD);
      check_b("basic_valid", out_valid_o, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      check_b("basic_valid_one_cycle", out_valid_o, 1'b0);
      check_b("basic_no_ferr", frame_err_o, 1'b0);

      // Truncated word, then a clean one
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_b("trunc_ferr", frame_err_o, 1'b1);
      check_b("trunc_busy", busy_o, 1'b0);
      check_b("trunc_valid", out_valid_o, 1'b0);
      idle(1, 1'b0);
      check_b("trunc_ferr_pulse", frame_err_o, 1'b0);
      send_word(4'h6, 1'b0);
      check_w("trunc_next_word", parallel_o, 4'h6);
      idle(1, 1'b1);

      // Overrun with consumer stalled
      send_word(4'hA, 1'b0);
      send_word(4'h5, 1'b0);
      check_w("ovr_kept_word", parallel_o, 4'hA);
      check_b("ovr_set", overrun_o, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_b("ovr_cleared", overrun_o, 1'b0);
      idle(1, 1'b1);

      // Back-to-back words with a handshake on the completing cycle
      send_word(4'h3, 1'b0);
      check_w("b2b_first", parallel_o, 4'h3);
      for (int i = 0; i < W - 1; i++) begin
         cyc(i >= 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         check_b("b2b_valid_held", out_valid_o, 1'b1);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check_w("b2b_second", parallel_o, 4'hC);
      check_b("b2b_no_bubble", out_valid_o, 1'b1);
      idle(1, 1'b1);

      // Gap timeout and a gap just under the limit
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(GAP_MAX - 1, 1'b0);
      check_b("gap_busy_before", busy_o, 1'b1);
      idle(1, 1'b0);
      check_b("gap_ferr", frame_err_o, 1'b1);
      check_b("gap_busy_after", busy_o, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(GAP_MAX - 1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_w("gap_ok_word", parallel_o, 4'hB);
      check_b("gap_ok_no_ferr", frame_err_o, 1'b0);
      idle(1, 1'b1);

      // Reset mid-word with a pending output
      send_word(4'h9, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_w("rst_mid_parallel", parallel_o, 4'h0);
      check_b("rst_mid_valid", out_valid_o, 1'b0);
      check_b("rst_mid_busy", busy_o, 1'b0);
      check_b("rst_mid_ferr", frame_err_o, 1'b0);
      send_word(4'h7, 1'b1);
      check_w("rst_next_word", parallel_o, 4'h7);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 49) == 0) begin
            idle(int'($urandom_range(GAP_MAX - 2, GAP_MAX + 2)), 1'($urandom_range(0, 1)));
         end else begin
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
